// File: rtl/mem_port_if.sv
// Requester, completion and memory-side signals of the shared memory port.
// slave = arbiter view, master = pipeline/memory environment view.
interface mem_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_done;
  logic                  if_stall;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wmask;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_done;
  logic                  d_stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ack;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata, mem_ack,
    output if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata, mem_ack,
    input  if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between fetch (IF) and load/store (MEM); data wins
// unless fetch has waited MAX_D_STREAK data grants. Access = 2+L cycles, req/ack held.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_port_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t     state, state_nxt;
  logic [3:0] streak, streak_nxt;
  logic       grant_i, grant_d;
  logic       streak_full;

  assign streak_full = (streak >= STREAK_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      streak <= 4'd0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    streak_nxt  = streak;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    bus.if_done = 1'b0;
    bus.d_done  = 1'b0;
    case (state)
      IDLE: begin
        // Fetch only overrides data once the streak has saturated.
        if (bus.d_req && !(bus.if_req && streak_full)) begin
          grant_d   = 1'b1;
          state_nxt = GRANT_D;
          if (bus.if_req)
            streak_nxt = streak_full ? STREAK_MAX : streak + 4'd1;
          else
            streak_nxt = 4'd0;
        end else if (bus.if_req) begin
          grant_i    = 1'b1;
          state_nxt  = GRANT_I;
          streak_nxt = 4'd0;
        end
      end
      GRANT_I: begin
        bus.if_done = bus.mem_ack;
        if (bus.mem_ack) state_nxt = IDLE;
      end
      GRANT_D: begin
        bus.d_done = bus.mem_ack;
        if (bus.mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data stay at their last values after ack; only mem_req drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wmask <= '0;
    end else if (grant_i) begin
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= bus.if_addr;
      bus.mem_wdata <= '0;
      bus.mem_wmask <= '0;
    end else if (grant_d) begin
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= bus.d_we;
      bus.mem_addr  <= bus.d_addr;
      bus.mem_wdata <= bus.d_wdata;
      bus.mem_wmask <= bus.d_we ? bus.d_wmask : '0;
    end else if (state != IDLE && bus.mem_ack) begin
      bus.mem_req   <= 1'b0;
    end
  end

  assign bus.if_rdata = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;
  assign bus.if_stall = bus.if_req & ~bus.if_done;
  assign bus.d_stall  = bus.d_req & ~bus.d_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table for single accesses, scoreboard for
// collision/starvation ordering, and reset-in-flight sequences.
module tb_mem_port_arbiter;
  localparam logic [31:0] KEY = 32'hA5A5_0F0F;

  logic clk;
  logic rst_n;

  mem_port_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: acks L cycles after mem_req rises, or a manual ack.
  int          lat;
  bit          auto_ack;
  logic        man_ack;
  logic        resp_ack;
  int          wait_cnt;
  bit          rd_ovr_en;
  logic [31:0] rd_ovr;

  assign bus.mem_ack   = auto_ack ? resp_ack : man_ack;
  assign bus.mem_rdata = rd_ovr_en ? rd_ovr : (bus.mem_addr ^ KEY);

  always @(posedge clk) begin
    #1;
    if (!bus.mem_req) begin
      resp_ack = 1'b0;
      wait_cnt = 0;
    end else begin
      resp_ack = (wait_cnt == lat);
      wait_cnt = wait_cnt + 1;
    end
  end

  int n_chk;
  int n_pass;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        is_i;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          lat;
    logic [31:0] rdata;
    logic        exp_we;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic        is_i;
    logic [31:0] addr;
  } sb_t;

  sb_t sb[$];
  int  d_left;
  int  i_left;

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    bit seen_done;
    cyc = 0;
    seen_done = 1'b0;
    lat = v.lat;
    rd_ovr_en = 1'b1;
    rd_ovr = v.rdata;
    bus.if_req  = v.is_i;
    bus.if_addr = v.is_i ? v.addr : 32'h0;
    bus.d_req   = !v.is_i;
    bus.d_we    = v.we;
    bus.d_addr  = v.is_i ? 32'h0 : v.addr;
    bus.d_wdata = v.wdata;
    bus.d_wmask = v.wmask;
    while (!seen_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_req) begin
        check($sformatf("v%0d_mem_addr", idx), 64'(bus.mem_addr), 64'(v.addr));
        check($sformatf("v%0d_mem_we", idx), 64'(bus.mem_we), 64'(v.exp_we));
        check($sformatf("v%0d_mem_wmask", idx), 64'(bus.mem_wmask), 64'(v.exp_wmask));
        if (!v.is_i)
          check($sformatf("v%0d_mem_wdata", idx), 64'(bus.mem_wdata), 64'(v.exp_wdata));
      end
      seen_done = v.is_i ? bus.if_done : bus.d_done;
      check($sformatf("v%0d_other_done", idx), 64'(v.is_i ? bus.d_done : bus.if_done), 64'd0);
      if (!seen_done) begin
        check($sformatf("v%0d_stall", idx), 64'(v.is_i ? bus.if_stall : bus.d_stall), 64'd1);
      end else begin
        check($sformatf("v%0d_stall_done", idx), 64'(v.is_i ? bus.if_stall : bus.d_stall), 64'd0);
        check($sformatf("v%0d_rdata", idx), 64'(v.is_i ? bus.if_rdata : bus.d_rdata), 64'(v.rdata));
        check($sformatf("v%0d_latency", idx), 64'(cyc), 64'(2 + v.lat));
      end
      @(posedge clk);
      #1;
    end
    if (!seen_done) check($sformatf("v%0d_timeout", idx), 64'd0, 64'd1);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_req_drop", idx), 64'(bus.mem_req), 64'd0);
    check($sformatf("v%0d_no_done", idx), 64'({bus.if_done, bus.d_done}), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Requesters re-issue until their counts run out; completions pop the scoreboard.
  task automatic run_txns(input string tag, input int budget);
    int  cyc;
    int  prev_cyc;
    bit  got_i;
    bit  got_d;
    sb_t e;
    cyc = 0;
    prev_cyc = 0;
    rd_ovr_en = 1'b0;
    while (sb.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      got_i = bus.if_done;
      got_d = bus.d_done;
      if (bus.if_req && !got_i)
        check({tag, "_if_stall"}, 64'(bus.if_stall), 64'd1);
      if (bus.d_req && !got_d)
        check({tag, "_d_stall"}, 64'(bus.d_stall), 64'd1);
      if (got_i || got_d) begin
        e = sb.pop_front();
        check({tag, "_kind_is_i"}, 64'(got_i), 64'(e.is_i));
        check({tag, "_addr"}, 64'(bus.mem_addr), 64'(e.addr));
        check({tag, "_rdata"}, 64'(got_i ? bus.if_rdata : bus.d_rdata), 64'(e.addr ^ KEY));
        check({tag, "_spacing"}, 64'(cyc - prev_cyc), 64'(2 + lat));
        prev_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (got_d) begin
        d_left--;
        if (d_left == 0) bus.d_req = 1'b0;
        else bus.d_addr = bus.d_addr + 32'd4;
      end
      if (got_i) begin
        i_left--;
        if (i_left == 0) bus.if_req = 1'b0;
        else bus.if_addr = bus.if_addr + 32'd4;
      end
    end
    if (sb.size() > 0) check({tag, "_timeout"}, 64'(sb.size()), 64'd0);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    sb.delete();
  endtask

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 32'h0,         4'h0, 0, 32'h0000_0013, 1'b0, 4'h0, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0204, 1'b1, 32'hDEAD_BEEF, 4'h3, 3, 32'h0,         1'b1, 4'h3, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h0000_0208, 1'b0, 32'h1234_5678, 4'hF, 1, 32'hCAFE_F00D, 1'b0, 4'h0, 32'h1234_5678};
    vecs[3] = '{1'b1, 32'h0000_03FC, 1'b1, 32'h0,         4'hF, 2, 32'h0050_0093, 1'b0, 4'h0, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0010, 1'b1, 32'h0102_0304, 4'h8, 0, 32'h0,         1'b1, 4'h8, 32'h0102_0304};

    rst_n = 1'b0;
    auto_ack = 1'b1;
    man_ack = 1'b0;
    lat = 0;
    rd_ovr_en = 1'b0;
    rd_ovr = 32'h0;
    bus.if_req = 1'b0;
    bus.if_addr = 32'h0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = 32'h0;
    bus.d_wdata = 32'h0;
    bus.d_wmask = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_mem_fields", 64'({bus.mem_we, bus.mem_wmask, bus.mem_addr}), 64'd0);
    check("rst_done", 64'({bus.if_done, bus.d_done}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Collision: D first, I granted from the IDLE cycle after d_done.
    lat = 1;
    d_left = 1;
    i_left = 1;
    sb.push_back('{1'b0, 32'h0000_0500});
    sb.push_back('{1'b1, 32'h0000_0600});
    bus.d_we = 1'b0;
    bus.d_addr = 32'h0000_0500;
    bus.if_addr = 32'h0000_0600;
    bus.d_req = 1'b1;
    bus.if_req = 1'b1;
    run_txns("collide", 60);

    // Starvation with MAX_D_STREAK=2: D,D,I,D,D,I then the last D.
    lat = 0;
    d_left = 5;
    i_left = 2;
    sb.push_back('{1'b0, 32'h0000_0300});
    sb.push_back('{1'b0, 32'h0000_0304});
    sb.push_back('{1'b1, 32'h0000_0400});
    sb.push_back('{1'b0, 32'h0000_0308});
    sb.push_back('{1'b0, 32'h0000_030C});
    sb.push_back('{1'b1, 32'h0000_0404});
    sb.push_back('{1'b0, 32'h0000_0310});
    bus.d_addr = 32'h0000_0300;
    bus.if_addr = 32'h0000_0400;
    bus.d_req = 1'b1;
    bus.if_req = 1'b1;
    run_txns("starve", 100);
    @(posedge clk);
    #1;

    // Reset while a store is granted and not yet acked.
    auto_ack = 1'b0;
    man_ack = 1'b0;
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 32'h0000_0700;
    bus.d_wdata = 32'h55AA_55AA;
    bus.d_wmask = 4'hF;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_granted", 64'(bus.mem_req), 64'd1);
    check("midrst_pre_done", 64'(bus.d_done), 64'd0);
    #2;
    man_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_mem_req", 64'(bus.mem_req), 64'd0);
    check("midrst_mem_we", 64'(bus.mem_we), 64'd0);
    check("midrst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("midrst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("midrst_mem_wmask", 64'(bus.mem_wmask), 64'd0);
    check("midrst_done", 64'({bus.if_done, bus.d_done}), 64'd0);
    bus.d_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("postrst_d_done%0d", k), 64'(bus.d_done), 64'd0);
      check($sformatf("postrst_mem_req%0d", k), 64'(bus.mem_req), 64'd0);
    end
    man_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single unified memory port shared by the pipeline's IF stage (instruction fetch) and MEM stage (load/store). It accepts one request from each stage and grants the port to one of them. It drives a req/ack transaction on the memory side and returns per-stage done and stall signals, which are ORed into the pipeline's stall/enable logic next to the hazard detection unit. Data accesses have priority, and a streak counter guarantees that fetch is never starved.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-mask width is DATA_W/8
- MAX_D_STREAK, 4, max consecutive data grants while if_req is pending (range 1..15)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word; valid only while if_done=1
- if_done  out  1  fetch completes this cycle
- if_stall  out  1  if_req & ~if_done
- d_req  in  1  data request; held until d_done
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wmask  in  DATA_W/8  store byte enables
- d_rdata  out  DATA_W  load data; valid only while d_done=1
- d_done  out  1  data access completes this cycle
- d_stall  out  1  d_req & ~d_done
- mem_req  out  1  memory request, registered
- mem_we  out  1  registered
- mem_addr  out  ADDR_W  registered
- mem_wdata  out  DATA_W  registered
- mem_wmask  out  DATA_W/8  registered; 0 for fetches and loads
- mem_rdata  in  DATA_W  read data; valid with mem_ack
- mem_ack  in  1  single-cycle completion strobe, latency ≥0 cycles after mem_req rises

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D.
- In IDLE, requests are evaluated at each rising edge:
  - d_req & ~(if_req & streak==MAX_D_STREAK) → GRANT_D.
  - else if if_req → GRANT_I.
  - else stay IDLE.
- On a grant, mem_req←1 and mem_addr, mem_we, mem_wdata, mem_wmask are latched from the winner. A fetch latches we=0 and wmask=0. A load latches wmask=0.
- In GRANT_x, the mem_* registers are held stable until mem_ack. When mem_ack=1 at an edge: state←IDLE, mem_req←0, and the other mem_* registers keep their values.
- Done signals are combinational:
  - if_done = (state==GRANT_I) & mem_ack, d_done = (state==GRANT_D) & mem_ack.
  - if_rdata = d_rdata = mem_rdata (pass-through).
- Requester inputs are ignored outside IDLE. A requester drops or changes its req at the edge that ends its done cycle, so a stale request is never re-granted.
- Streak counter, 4 bits:
  - On a D grant with if_req=1: +1, saturating at MAX_D_STREAK.
  - On a D grant with if_req=0: ←0.
  - On an I grant: ←0.
- mem_ack in IDLE is ignored and produces no done.
- Reset (async, rst_n=0): state=IDLE and streak=0. mem_req, mem_we, mem_addr, mem_wdata and mem_wmask all go to 0 immediately. Consequently if_done=d_done=0. An ack still outstanding when reset is released is ignored.

## Timing
- Request sampled at edge N → mem_req=1 from cycle N+1.
- Ack in cycle N+1+L (L≥0) → done=1 in the same cycle, and mem_req=0 from the next cycle.
- Minimum cost is 2 cycles per access, with no back-to-back grant without passing through IDLE. Stall length = 2+L cycles, counted from the cycle in which req first rises in IDLE.
- Simultaneous if_req and d_req in IDLE: D wins unless streak==MAX_D_STREAK.
- A new request arriving while the port is busy is held by the requester and evaluated in the next IDLE cycle.

## Test plan
- Reset: assert rst_n=0 mid-sim → mem_req, mem_we, mem_addr, mem_wmask, if_done and d_done are all 0 in the same cycle. State returns to IDLE.
- Single fetch, L=0: if_req=1, if_addr=0x100 at cycle 0 → mem_req=1, mem_addr=0x100, mem_we=0 in cycle 1. With mem_ack=1 and mem_rdata=0x00000013 in cycle 1 → if_done=1, if_rdata=0x13, and if_stall=0 in cycle 1. mem_req=0 in cycle 2.
- Store, L=3: d_req=1, d_we=1, d_addr=0x204, d_wdata=0xDEADBEEF, d_wmask=4'b0011 → the mem_* outputs hold those values stably for 4 cycles, and d_stall=1 until the ack cycle. d_done=1 only in the ack cycle.
- Collision: if_req and d_req both rise in cycle 0 → the D access is served first. The I grant occurs in the IDLE cycle after d_done, and if_stall stays high throughout.
- Starvation, MAX_D_STREAK=2: hold if_req, and re-issue d_req continuously with L=0 → grant order D,D,I,D,D,I.
- Reset mid-access: in GRANT_D with no ack, pull rst_n low → mem_req drops immediately. After release, mem_ack=1 in IDLE → no d_done, and mem_req stays 0.
